// File: rtl/fma_unpack_stage.sv
// FMA input stage: unpacks and classifies three IEEE-754 operands, registered output
// behind a 2-entry skid buffer so in_ready never combinationally depends on out_ready.
module fma_unpack_stage #(
  parameter int WIDTH = 64,
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign_p,
  output logic             out_sign_c,
  output logic [EXP_W-1:0] out_exp_a,
  output logic [EXP_W-1:0] out_exp_b,
  output logic [EXP_W-1:0] out_exp_c,
  output logic [MAN_W:0]   out_sig_a,
  output logic [MAN_W:0]   out_sig_b,
  output logic [MAN_W:0]   out_sig_c,
  output logic [11:0]      out_class,
  output logic             out_invalid,
  output logic             out_special
);

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   sig;
    logic [3:0]       cls;   // {nan,inf,sub,zero}
    logic             snan;
  } opnd_t;

  typedef struct packed {
    logic             sign_p;
    logic             sign_c;
    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] exp_b;
    logic [EXP_W-1:0] exp_c;
    logic [MAN_W:0]   sig_a;
    logic [MAN_W:0]   sig_b;
    logic [MAN_W:0]   sig_c;
    logic [11:0]      cls;
    logic             invalid;
    logic             special;
  } trip_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  function automatic opnd_t unpack(input logic [WIDTH-1:0] x);
    opnd_t            o;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    e      = x[WIDTH-2 -: EXP_W];
    m      = x[MAN_W-1:0];
    o.sign = x[WIDTH-1];
    o.exp  = e;
    o.sig  = {1'b1, m};
    o.cls  = 4'b0000;
    o.snan = 1'b0;
    if (e == '0) begin
      // zero and subnormal share the minimum effective exponent
      o.exp = EXP_ONE;
      o.sig = {1'b0, m};
      o.cls = (m == '0) ? 4'b0001 : 4'b0010;
    end else if (&e) begin
      o.cls  = (m == '0) ? 4'b0100 : 4'b1000;
      o.snan = (m != '0) && !m[MAN_W-1];
    end
    return o;
  endfunction

  opnd_t  ua, ub, uc;
  trip_t  in_trip;
  logic   prod_inf;

  always_comb begin
    ua = unpack(in_a);
    ub = unpack(in_b);
    uc = unpack(in_c);
    in_trip        = '0;
    in_trip.sign_p = ua.sign ^ ub.sign;
    in_trip.sign_c = uc.sign;
    in_trip.exp_a  = ua.exp;
    in_trip.exp_b  = ub.exp;
    in_trip.exp_c  = uc.exp;
    in_trip.sig_a  = ua.sig;
    in_trip.sig_b  = ub.sig;
    in_trip.sig_c  = uc.sig;
    in_trip.cls    = {uc.cls, ub.cls, ua.cls};
    // product is a true infinity only when neither factor is NaN or zero
    prod_inf = (ua.cls[2] | ub.cls[2]) & ~ua.cls[3] & ~ub.cls[3] & ~ua.cls[0] & ~ub.cls[0];
    in_trip.invalid = ua.snan | ub.snan | uc.snan
                    | (ua.cls[2] & ub.cls[0]) | (ua.cls[0] & ub.cls[2])
                    | (prod_inf & uc.cls[2] & (in_trip.sign_p != uc.sign));
    in_trip.special = ua.cls[3] | ub.cls[3] | uc.cls[3]
                    | ua.cls[2] | ub.cls[2] | uc.cls[2]
                    | ua.cls[0] | ub.cls[0];
  end

  state_t state_q, state_d;
  trip_t  main_q, main_d, skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  logic   in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = (state_q != EMPTY) & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (in_fire) begin
        main_d  = in_trip;
        state_d = ONE;
      end
      ONE: begin
        if (in_fire && out_fire) main_d = in_trip;
        else if (in_fire) begin
          skid_d  = in_trip;
          state_d = FULL;
        end else if (out_fire) state_d = EMPTY;
      end
      FULL: if (out_fire) begin
        main_d  = skid_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    // computed from next state so the flop matches the state it will sit beside
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != EMPTY);
  assign out_sign_p  = main_q.sign_p;
  assign out_sign_c  = main_q.sign_c;
  assign out_exp_a   = main_q.exp_a;
  assign out_exp_b   = main_q.exp_b;
  assign out_exp_c   = main_q.exp_c;
  assign out_sig_a   = main_q.sig_a;
  assign out_sig_b   = main_q.sig_b;
  assign out_sig_c   = main_q.sig_c;
  assign out_class   = main_q.cls;
  assign out_invalid = main_q.invalid;
  assign out_special = main_q.special;

endmodule

// File: tb/tb_fma_unpack_stage.sv
// Bench for fma_unpack_stage: table of hand-derived vectors fed through a scoreboard,
// plus backpressure, latency and mid-operation reset sequences.
module tb_fma_unpack_stage;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [63:0] in_a = '0, in_b = '0, in_c = '0;
  logic        out_sign_p, out_sign_c, out_invalid, out_special;
  logic [10:0] out_exp_a, out_exp_b, out_exp_c;
  logic [52:0] out_sig_a, out_sig_b, out_sig_c;
  logic [11:0] out_class;

  fma_unpack_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign_p(out_sign_p), .out_sign_c(out_sign_c),
    .out_exp_a(out_exp_a), .out_exp_b(out_exp_b), .out_exp_c(out_exp_c),
    .out_sig_a(out_sig_a), .out_sig_b(out_sig_b), .out_sig_c(out_sig_c),
    .out_class(out_class), .out_invalid(out_invalid), .out_special(out_special)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sp, sc;
    logic [10:0] ea; logic [52:0] sa;
    logic [10:0] eb; logic [52:0] sb;
    logic [10:0] ec; logic [52:0] sgc;
    logic [11:0] cls;
    logic        inv, spc;
  } exp_t;

  typedef struct packed {
    logic [63:0] a, b, c;
    exp_t        e;
  } vec_t;

  localparam int NV = 9;
  localparam logic [63:0] ONE_D = 64'h3FF0000000000000;
  localparam logic [52:0] S1    = 53'h10000000000000;

  vec_t vec [NV];
  exp_t q [$];
  int   nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // scoreboard: every output transfer is matched against the oldest accepted triple
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("sign_p", 64'(out_sign_p), 64'(e.sp));
        chk("sign_c", 64'(out_sign_c), 64'(e.sc));
        chk("exp_a", 64'(out_exp_a), 64'(e.ea));
        chk("sig_a", 64'(out_sig_a), 64'(e.sa));
        chk("exp_b", 64'(out_exp_b), 64'(e.eb));
        chk("sig_b", 64'(out_sig_b), 64'(e.sb));
        chk("exp_c", 64'(out_exp_c), 64'(e.ec));
        chk("sig_c", 64'(out_sig_c), 64'(e.sgc));
        chk("class", 64'(out_class), 64'(e.cls));
        chk("invalid", 64'(out_invalid), 64'(e.inv));
        chk("special", 64'(out_special), 64'(e.spc));
      end
    end
  end

  task automatic send(input int i);
    bit done = 0;
    in_valid = 1'b1;
    in_a = vec[i].a; in_b = vec[i].b; in_c = vec[i].c;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(vec[i].e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
  endtask

  initial begin
    //               a                      b                      c
    vec[0] = '{64'h3FF8000000000000, 64'h4000000000000000, 64'hBFF0000000000000,
               '{1'b0, 1'b1, 11'h3FF, 53'h18000000000000, 11'h400, S1, 11'h3FF, S1, 12'h000, 1'b0, 1'b0}};
    vec[1] = '{64'h7FF0000000000000, 64'h0, 64'h0,
               '{1'b0, 1'b0, 11'h7FF, S1, 11'h001, 53'h0, 11'h001, 53'h0, 12'h114, 1'b1, 1'b1}};
    vec[2] = '{64'h7FF4000000000000, ONE_D, ONE_D,
               '{1'b0, 1'b0, 11'h7FF, 53'h14000000000000, 11'h3FF, S1, 11'h3FF, S1, 12'h008, 1'b1, 1'b1}};
    vec[3] = '{ONE_D, ONE_D, 64'h0000000000000001,
               '{1'b0, 1'b0, 11'h3FF, S1, 11'h3FF, S1, 11'h001, 53'h1, 12'h200, 1'b0, 1'b0}};
    vec[4] = '{64'h7FF0000000000000, ONE_D, 64'hFFF0000000000000,
               '{1'b0, 1'b1, 11'h7FF, S1, 11'h3FF, S1, 11'h7FF, S1, 12'h404, 1'b1, 1'b1}};
    vec[5] = '{64'h7FF8000000000000, 64'h0, ONE_D,
               '{1'b0, 1'b0, 11'h7FF, 53'h18000000000000, 11'h001, 53'h0, 11'h3FF, S1, 12'h018, 1'b0, 1'b1}};
    vec[6] = '{64'h8000000000000000, 64'h7FF0000000000000, ONE_D,
               '{1'b1, 1'b0, 11'h001, 53'h0, 11'h7FF, S1, 11'h3FF, S1, 12'h041, 1'b1, 1'b1}};
    vec[7] = '{64'h7FF0000000000000, ONE_D, 64'h7FF0000000000000,
               '{1'b0, 1'b0, 11'h7FF, S1, 11'h3FF, S1, 11'h7FF, S1, 12'h404, 1'b0, 1'b1}};
    vec[8] = '{64'h000FFFFFFFFFFFFF, ONE_D, ONE_D,
               '{1'b0, 1'b0, 11'h001, 53'h0FFFFFFFFFFFFF, 11'h3FF, S1, 11'h3FF, S1, 12'h002, 1'b0, 1'b0}};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk); rst = 1'b0;
    #1 chk("in_ready_at_release", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("in_ready_after_release", 64'(in_ready), 64'd1);
    chk("out_valid_idle", 64'(out_valid), 64'd0);

    // single-cycle latency into an empty buffer
    send(0);
    chk("latency_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    // table vectors, full throughput
    for (int i = 1; i < NV; i++) send(i);
    @(posedge clk); #1;
    chk("drained_valid", 64'(out_valid), 64'd0);

    // backpressure: two triples fill the buffer, third waits
    out_ready = 1'b0;
    send(3);
    send(4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    repeat (2) @(posedge clk);
    #1 chk("held_class", 64'(out_class), 64'h200);
    fork
      send(5);
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("no_gap", 64'(out_valid), 64'd1);
        end
      end
    join
    @(posedge clk); #1;

    // reset while full discards everything
    out_ready = 1'b0;
    send(6);
    send(7);
    chk("full2_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd0);
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_stale_after_rst", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    send(8);

    for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
    chk("scoreboard_drain", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
